// File: rtl/async_pipe_pkg.sv
// async_pipe_pkg: shared FSM encodings, default width and clog2 helper for the async-pipeline blocks
package async_pipe_pkg;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACK_HI  = 2'd1;
    localparam logic [1:0] ST_WAIT_LO = 2'd2;
    localparam int DEFAULT_DATA_W = 8;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/async_hs_rx_if.sv
// async_hs_rx_if: 4-phase bundled-data input plus valid/ready output stream of the async receiver
//   req_in/data_in/ack_out : 4-phase handshake with the pipeline tail
//   out_valid/out_data/out_ready : synchronous stream from the FIFO head
//   fifo_level : FIFO occupancy
//   modport slave = receiver view, modport master = pipeline/sink view
interface async_hs_rx_if import async_pipe_pkg::*; #(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = clog2(FIFO_DEPTH) + 1;
    logic              req_in;
    logic [DATA_W-1:0] data_in;
    logic              ack_out;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [LVL_W-1:0]  fifo_level;
    modport slave  (input  req_in, data_in, out_ready, output ack_out, out_valid, out_data, fifo_level);
    modport master (output req_in, data_in, out_ready, input  ack_out, out_valid, out_data, fifo_level);
endinterface

// File: rtl/sync_nff.sv
// sync_nff: STAGES-deep flop chain synchronizer, async active-low reset to 0
//   clk, rst_n : clock and reset
//   d : asynchronous input, q : synchronized output
module sync_nff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q, sync_d;
    always_comb sync_d = {sync_q[STAGES-2:0], d};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/async_hs_rx.sv
// async_hs_rx: clocked receiver turning 4-phase bundled-data transfers into a FIFO-buffered valid/ready stream
//   clk, rst_n : system clock, async active-low reset
//   bus (slave) : req_in/data_in/ack_out handshake, out_valid/out_data/out_ready stream, fifo_level
//   ASYNC_HS_RX_CNT_EN adds rx_count (saturating write count) and stall_flag (req pending on full FIFO)
module async_hs_rx import async_pipe_pkg::*; #(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    async_hs_rx_if.slave bus
`ifdef ASYNC_HS_RX_CNT_EN
    ,
    output logic [15:0]  rx_count,
    output logic         stall_flag
`endif
);
    localparam int AW = clog2(FIFO_DEPTH);
    logic              req_s;
    logic [1:0]        state_q, state_d;
    logic              ack_q, ack_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic              full, empty, push, pop;

    sync_nff #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .d(bus.req_in), .q(req_s));

    always_comb begin
        empty    = wr_ptr_q == rd_ptr_q;
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push     = (state_q == ST_IDLE) && req_s && !full;
        pop      = !empty && bus.out_ready;
        state_d  = push                               ? ST_ACK_HI  :
                   (state_q == ST_ACK_HI && !req_s)   ? ST_WAIT_LO :
                   (state_q == ST_WAIT_LO)            ? ST_IDLE    : state_q;
        ack_d    = state_d == ST_ACK_HI;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end

    // Storage needs no reset: contents are only visible through out_valid.
    always_ff @(posedge clk)
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.data_in;

    assign bus.ack_out    = ack_q;
    assign bus.out_valid  = !empty;
    assign bus.out_data   = mem_q[rd_ptr_q[AW-1:0]];
    assign bus.fifo_level = wr_ptr_q - rd_ptr_q;

`ifdef ASYNC_HS_RX_CNT_EN
    logic [15:0] rx_count_q, rx_count_d;
    always_comb rx_count_d = (push && rx_count_q != 16'hFFFF) ? rx_count_q + 16'd1 : rx_count_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rx_count_q <= '0;
        else        rx_count_q <= rx_count_d;
    assign rx_count   = rx_count_q;
    assign stall_flag = (state_q == ST_IDLE) && req_s && full;
`endif
endmodule

// File: tb/tb_async_hs_rx.sv
// tb_async_hs_rx: scoreboard bench for async_hs_rx (directed scenarios plus randomized traffic)
module tb_async_hs_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    async_hs_rx_if #(.DATA_W(8), .FIFO_DEPTH(4)) bus ();
`ifdef ASYNC_HS_RX_CNT_EN
    logic [15:0] rx_count;
    logic        stall_flag;
`endif

    async_hs_rx #(.DATA_W(8), .SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef ASYNC_HS_RX_CNT_EN
        ,
        .rx_count(rx_count),
        .stall_flag(stall_flag)
`endif
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];
    int         accepted = 0;
    int         popped = 0;
    logic       prev_ack = 1'b0;
    bit         rnd_rdy = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: level model = words acknowledged minus words consumed; data order from the queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            accepted = 0;
            popped   = 0;
            prev_ack = 1'b0;
        end else begin
            if (bus.ack_out && !prev_ack) accepted++;
            prev_ack = bus.ack_out;
            chk("level", bus.fifo_level, accepted - popped);
            chk("valid", bus.out_valid, accepted != popped);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL pop: got %0h expected none (queue empty)", bus.out_data);
                end else chk("data", bus.out_data, exp_q.pop_front());
                popped++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_ack(input logic lvl, input int lim, output int n);
        n = 0;
        while (bus.ack_out !== lvl && n < lim) begin
            cyc(1);
            n++;
        end
        if (bus.ack_out !== lvl) begin
            n_cmp++;
            n_err++;
            $display("FAIL ack_timeout: got %b expected %b", bus.ack_out, lvl);
        end
    endtask

    task automatic hs(input logic [7:0] d, output int rl, output int fl);
        bus.data_in = d;
        bus.req_in  = 1'b1;
        exp_q.push_back(d);
        wait_ack(1'b1, 100, rl);
        bus.req_in = 1'b0;
        wait_ack(1'b0, 100, fl);
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        while (bus.fifo_level != 0 && n < 100) begin
            cyc(1);
            n++;
        end
        chk("drain_level", bus.fifo_level, 0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rl, fl, n;
        bit stall_seen;
        int cnt0;
        bus.req_in = 1'b0;
        bus.data_in = '0;
        bus.out_ready = 1'b0;
        cnt0 = 0;
        cyc(3);
        chk("rst_ack", bus.ack_out, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_level", bus.fifo_level, 0);
        rst_n = 1'b1;
        cyc(2);

        // single transfer and latency
        hs(8'hA5, rl, fl);
        chk("rise_lat", rl, 3);
        chk("fall_lat", fl, 3);
        chk("single_valid", bus.out_valid, 1);
        chk("single_data", bus.out_data, 8'hA5);
        chk("single_level", bus.fifo_level, 1);
        drain();

        // full backpressure
`ifdef ASYNC_HS_RX_CNT_EN
        cnt0 = int'(rx_count);
`endif
        for (int i = 1; i <= 4; i++) hs(8'(i), rl, fl);
        chk("bp_level", bus.fifo_level, 4);
        bus.data_in = 8'h05;
        bus.req_in  = 1'b1;
        exp_q.push_back(8'h05);
        stall_seen = 1'b0;
        repeat (10) begin
            cyc(1);
`ifdef ASYNC_HS_RX_CNT_EN
            if (stall_flag) stall_seen = 1'b1;
`endif
        end
        chk("bp_stall_ack", bus.ack_out, 0);
        chk("bp_stall_level", bus.fifo_level, 4);
        bus.out_ready = 1'b1;
        cyc(1);
        bus.out_ready = 1'b0;
        wait_ack(1'b1, 20, n);
        chk("bp_after_level", bus.fifo_level, 4);
`ifdef ASYNC_HS_RX_CNT_EN
        chk("rx_count", int'(rx_count) - cnt0, 5);
        chk("stall_seen", stall_seen, 1);
`endif
        bus.req_in = 1'b0;
        wait_ack(1'b0, 20, n);
        drain();

        // simultaneous push and pop at level 2
        hs(8'h21, rl, fl);
        hs(8'h22, rl, fl);
        chk("sim_pre_level", bus.fifo_level, 2);
        bus.data_in = 8'h23;
        bus.req_in  = 1'b1;
        exp_q.push_back(8'h23);
        cyc(2);
        bus.out_ready = 1'b1;
        cyc(1);
        bus.out_ready = 1'b0;
        chk("sim_ack", bus.ack_out, 1);
        chk("sim_level", bus.fifo_level, 2);
        bus.req_in = 1'b0;
        wait_ack(1'b0, 20, n);
        drain();

        // pointer wrap with sink always ready
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) hs(8'h10 + 8'(i), rl, fl);
        drain();

        // randomized data and sink readiness
        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++) hs(8'($urandom), rl, fl);
        rnd_rdy = 1'b0;
        drain();

        // reset mid-handshake
        hs(8'h31, rl, fl);
        hs(8'h32, rl, fl);
        bus.data_in = 8'h33;
        bus.req_in  = 1'b1;
        wait_ack(1'b1, 20, n);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", bus.ack_out, 0);
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_level", bus.fifo_level, 0);
        bus.req_in = 1'b0;
        exp_q.delete();
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        hs(8'h3C, rl, fl);
        chk("post_rst_lat", rl, 3);
        chk("post_rst_data", bus.out_data, 8'h3C);
        drain();

        cyc(2);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
